// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, range/alignment check on the fetch
// address, and a RUN/FAULT state machine that parks the PC on an illegal fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic        fetch_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  // Upper bound kept at 33 bits so RESET_PC near the top of memory cannot overflow.
  localparam logic [32:0] LIMIT_PC = {1'b0, RESET_PC} + (33'(IMEM_WORDS) << 2);

  function automatic logic fetch_legal(input logic [31:0] addr);
    fetch_legal = (addr[1:0] == 2'b00) &&
                  (addr >= RESET_PC) &&
                  ({1'b0, addr} < LIMIT_PC);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        legal_s;

  assign legal_s = fetch_legal(pc_q);

  // Next-state logic for pc, state, fault address and fetch counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      RUN: begin
        if (EN) begin
          if (legal_s) begin
            pc_d          = redirect ? redirect_target : (pc_q + 32'd4);
            fetch_count_d = fetch_count_q + 32'd1;
          end else begin
            state_d    = FAULT;
            fault_pc_d = pc_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      FAULT: begin
        if (EN && redirect) begin
          pc_d    = redirect_target;
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fault_pc_q    <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Fetch outputs follow pc in the same cycle; illegal or faulted fetches become a nop.
  always_comb begin
    imem_addr   = pc_q;
    PC          = pc_q;
    fetch_valid = 1'b0;
    instr       = 32'h0000_0000;
    if ((state_q == RUN) && legal_s) begin
      fetch_valid = 1'b1;
      instr       = imem_rdata;
    end else begin
      fetch_valid = 1'b0;
      instr       = 32'h0000_0000;
    end
  end

  assign fault       = (state_q == FAULT);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter IMEM_WORDS, default 4096, instruction memory depth in 32-bit words.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock, the only clock in the block.
REQ-005 reset  input  1  synchronous reset, active-low (0 = reset).
REQ-006 EN  input  1  advance enable from the hazard unit: 1 = advance, 0 = stall (hold).
REQ-007 redirect  input  1  taken branch or jump resolved in ID.
REQ-008 redirect_target  input  32  next fetch address when redirect is taken.
REQ-009 imem_addr  output  32  instruction memory byte address; equals PC.
REQ-010 imem_rdata  input  32  combinational instruction memory read data for imem_addr.
REQ-011 instr  output  32  instruction presented to the IF_ID register instr input.
REQ-012 PC  output  32  fetch address presented to the IF_ID register PC input.
REQ-013 fetch_valid  output  1  instr/PC hold a legal fetch.
REQ-014 fault  output  1  fetch fault state is active.
REQ-015 fault_pc  output  32  address that caused the most recent fault.
REQ-016 fetch_count  output  32  number of legal fetches accepted downstream.

Function
REQ-017 The block SHALL have a state register with two states: RUN and FAULT.
REQ-018 The illegal condition SHALL be combinational: PC[1:0] != 0, or PC < RESET_PC, or PC >= RESET_PC + 4*IMEM_WORDS.
REQ-019 imem_addr and PC SHALL always equal the internal pc register.
REQ-020 In RUN with PC legal: instr = imem_rdata and fetch_valid = 1.
REQ-021 Otherwise: instr = 32'h0000_0000 (nop) and fetch_valid = 0.
REQ-022 In RUN with EN=1 and PC legal, next pc SHALL be redirect_target if redirect=1, else pc+4.
REQ-023 pc+4 SHALL wrap modulo 2^32; a wrapped address is then treated as illegal per REQ-018.
REQ-024 EN=0 SHALL hold pc, state and fetch_count, regardless of redirect.
REQ-025 In RUN with EN=1 and PC illegal, on the clock edge the block SHALL:
- enter FAULT;
- set fault_pc = PC;
- hold pc.
REQ-026 In RUN with EN=0 and PC illegal, the block SHALL NOT enter FAULT; instr is still nop per REQ-021.
REQ-027 In FAULT with EN=1 and redirect=1, the block SHALL load pc = redirect_target and return to RUN; the new target is then checked per REQ-018.
REQ-028 In FAULT without (EN=1 and redirect=1), the block SHALL hold pc, fault_pc and state.
REQ-029 fault SHALL be 1 exactly when state = FAULT.
REQ-030 fetch_count SHALL increment by 1 on each edge where state = RUN, PC is legal and EN = 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-031 Redirect to the current PC SHALL re-fetch the same address; this is legal and counted.
REQ-032 Latency: a change in pc SHALL appear on imem_addr, PC and instr in the same cycle (zero-cycle combinational output path).

Reset
REQ-033 While reset=0 at a rising edge, the block SHALL set pc = RESET_PC, state = RUN, fault_pc = 0 and fetch_count = 0, overriding EN and redirect.
REQ-034 After reset with default parameters: PC = 32'h0000_3000, fault = 0, and fetch_valid = 1.
REQ-035 Reset asserted in FAULT or mid-stall SHALL return to the REQ-033 values on the next edge.

Verification
REQ-036 Sequential fetch: reset, then EN=1 and redirect=0 for 4 cycles -> PC sequence 3000, 3004, 3008, 300C; fetch_count = 4; instr tracks imem_rdata.
REQ-037 Stall: at PC=3008 hold EN=0 for 3 cycles with redirect=1 and target 3100 -> PC stays 3008 and fetch_count is unchanged; after EN=1, the next PC = 3100.
REQ-038 Branch: at PC=3004 with EN=1, redirect=1, target 3040 -> next PC = 3040; fetch_count increments by 1.
REQ-039 Misaligned fault: redirect to 3042 -> then:
- in that cycle, instr = 0 and fetch_valid = 0;
- on the next edge with EN=1, fault = 1 and fault_pc = 3042;
- PC stays 3042 while redirect=0.
REQ-040 Fault recovery: in FAULT, apply EN=1, redirect=1, target 3010 -> state RUN, PC = 3010, fault = 0; fault_pc stays 3042.
REQ-041 Range and reset: redirect to 7000 (beyond 3000 + 16 KiB) -> fault with fault_pc = 7000; then reset=0 for 1 cycle -> PC = 3000, fault = 0, fault_pc = 0, fetch_count = 0.
